// File: rtl/a2d_pkg.sv
// a2d_pkg: types and constants shared by the A2D round-robin scheduler,
// its timer and the testbench ADC model.
//   state_t   : scheduler FSM states
//   rot_idx_t : 2-bit rotation index (0 lft, 1 rght, 2 steer, 3 batt)
//   CH_*      : ADC128S channel numbers for each rotation slot
//   cmd_word  : builds the 16-bit SPI command frame for a channel
package a2d_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT1,
    S_GAP,
    S_READ,
    S_WAIT2,
    S_CAPT
  } state_t;

  typedef logic [1:0] rot_idx_t;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  // ADC128S control word: channel address sits in bits [13:11].
  function automatic logic [15:0] cmd_word(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_sched_if.sv
// a2d_sched_if: handshake between the scheduler and the SPI monarch.
//   wrt     : one-cycle strobe starting a 16-bit frame (scheduler -> SPI)
//   wt_data : frame to send                            (scheduler -> SPI)
//   done    : one-cycle frame-complete pulse           (SPI -> scheduler)
//   rd_data : received word, result in [11:0]          (SPI -> scheduler)
interface a2d_sched_if;

  logic        wrt;
  logic [15:0] wt_data;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output wt_data, input done, input rd_data);
  modport slave  (input wrt, input wt_data, output done, output rd_data);

endinterface

// File: rtl/a2d_sched_tmr.sv
// a2d_sched_tmr: loadable down-counter with terminal-count flag.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle (takes priority over en)
//   load_val : value to load
//   en       : decrement by one while count is non-zero
//   tc       : high while the count is zero
module a2d_sched_tmr #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign tc = (cnt_reg == '0);

endmodule

// File: rtl/a2d_sched.sv
// a2d_sched: round-robin scheduler sharing one ADC128S SPI link among the
// left/right load cells, steering pot and battery. Each nxt runs a command
// frame, a dead-time gap, then a read frame whose result lands in the
// channel's holding register.
//   clk, rst      : clock, synchronous active-high reset
//   nxt           : one-cycle request to convert the next channel
//   spi           : master side of the SPI monarch handshake
//   lft_ld, rght_ld, steer_pot, batt : latest 12-bit samples
//   smpl_vld      : one-cycle pulse when a holding register updates
//   smpl_idx      : rotation index qualified by smpl_vld
//   busy          : FSM is not idle
//   ovrrun        : sticky, a request was dropped (pending already set)
//   tmo_err       : sticky, done did not arrive within TMO_CYC clocks
module a2d_sched #(
  parameter logic [2:0] CH_LFT   = a2d_pkg::CH_LFT,
  parameter logic [2:0] CH_RGHT  = a2d_pkg::CH_RGHT,
  parameter logic [2:0] CH_STEER = a2d_pkg::CH_STEER,
  parameter logic [2:0] CH_BATT  = a2d_pkg::CH_BATT,
  parameter int         GAP_CYC  = 4,
  parameter int         TMO_CYC  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nxt,
  a2d_sched_if.master       spi,
  output logic [11:0]       lft_ld,
  output logic [11:0]       rght_ld,
  output logic [11:0]       steer_pot,
  output logic [11:0]       batt,
  output logic              smpl_vld,
  output logic [1:0]        smpl_idx,
  output logic              busy,
  output logic              ovrrun,
  output logic              tmo_err
);
  import a2d_pkg::*;

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  // One counter serves both the gap dwell and the timeout, so size it for the larger.
  localparam int TW    = (GAP_W > TMO_W) ? GAP_W : TMO_W;

  state_t      state_reg, state_next;
  rot_idx_t    idx_reg;
  logic        pend_reg;
  logic        ovr_reg;
  logic        tmo_reg;
  logic [15:0] wt_data_reg;
  logic [11:0] hold_reg [4];

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_en;
  logic          tmr_tc;
  logic [2:0]    chnl;
  logic          cap_we;
  logic          timeout;
  logic          unused_rd_hi;

  a2d_sched_tmr #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_comb begin
    chnl = CH_LFT;
    case (idx_reg)
      2'd0:    chnl = CH_LFT;
      2'd1:    chnl = CH_RGHT;
      2'd2:    chnl = CH_STEER;
      default: chnl = CH_BATT;
    endcase
  end

  // Loading TMO_CYC-1 on the frame strobe makes the wait state last at most
  // TMO_CYC clocks; loading GAP_CYC-1 on done gives GAP_CYC clocks in GAP.
  always_comb begin
    state_next = state_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
    case (state_reg)
      S_IDLE: if (nxt || pend_reg) state_next = S_CMD;
      S_CMD: begin
        state_next = S_WAIT1;
        tmr_load   = 1'b1;
        tmr_val    = TW'(TMO_CYC - 1);
      end
      S_WAIT1: begin
        if (spi.done) begin
          state_next = S_GAP;
          tmr_load   = 1'b1;
          tmr_val    = TW'(GAP_CYC - 1);
        end else if (tmr_tc) begin
          state_next = S_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_tc) state_next = S_READ;
        else        tmr_en     = 1'b1;
      end
      S_READ: begin
        state_next = S_WAIT2;
        tmr_load   = 1'b1;
        tmr_val    = TW'(TMO_CYC - 1);
      end
      S_WAIT2: begin
        if (spi.done)    state_next = S_CAPT;
        else if (tmr_tc) state_next = S_IDLE;
        else             tmr_en     = 1'b1;
      end
      S_CAPT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The holding register is written on the read-frame done so its output
  // changes in the CAPT cycle, alongside smpl_vld.
  assign cap_we  = (state_reg == S_WAIT2) && spi.done;
  assign timeout = ((state_reg == S_WAIT1) || (state_reg == S_WAIT2)) && !spi.done && tmr_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      pend_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
      tmo_reg     <= 1'b0;
      wt_data_reg <= '0;
      for (int i = 0; i < 4; i++) hold_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_IDLE) && (state_next == S_CMD)) wt_data_reg <= cmd_word(chnl);
      if (nxt && (state_reg != S_IDLE)) begin
        if (pend_reg) ovr_reg  <= 1'b1;
        else          pend_reg <= 1'b1;
      end else if (state_reg == S_IDLE) begin
        // A pending request is consumed now; a simultaneous nxt re-arms it.
        pend_reg <= pend_reg & nxt;
      end
      if (timeout) tmo_reg <= 1'b1;
      if (cap_we) hold_reg[idx_reg] <= spi.rd_data[11:0];
      if ((state_reg == S_CAPT) || timeout) idx_reg <= idx_reg + 2'd1;
    end
  end

  assign unused_rd_hi = &{1'b0, spi.rd_data[15:12]};

  assign spi.wrt     = (state_reg == S_CMD) || (state_reg == S_READ);
  assign spi.wt_data = wt_data_reg;
  assign busy        = (state_reg != S_IDLE);
  assign smpl_vld    = (state_reg == S_CAPT);
  assign smpl_idx    = idx_reg;
  assign ovrrun      = ovr_reg;
  assign tmo_err     = tmo_reg;
  assign lft_ld      = hold_reg[0];
  assign rght_ld     = hold_reg[1];
  assign steer_pot   = hold_reg[2];
  assign batt        = hold_reg[3];

endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: directed sequence with randomized ADC data and SPI latency,
// checked against a rotation/holding-register model and an ADC128S stub.
module tb_a2d_sched;
  import a2d_pkg::*;

  localparam int GAP_CYC = 4;
  localparam int TMO_CYC = 2048;

  logic        clk, rst, nxt;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        smpl_vld, busy, ovrrun, tmo_err;
  logic [1:0]  smpl_idx;

  a2d_sched_if spi ();

  a2d_sched #(.GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .nxt(nxt), .spi(spi),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
    .smpl_vld(smpl_vld), .smpl_idx(smpl_idx), .busy(busy),
    .ovrrun(ovrrun), .tmo_err(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  int          chan_tbl [4] = '{int'(CH_LFT), int'(CH_RGHT), int'(CH_STEER), int'(CH_BATT)};
  logic [11:0] adc_val [8];

  // stub / monitor state (written only by the monitor process)
  logic        stub_done = 1'b0;
  logic [15:0] stub_rd   = 16'h0;
  int lat = 0, cur_ch = 0, ret_ch = 0, cyc = 0, wrt_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  logic prev_wrt = 1'b0;
  int vld_q[$], vld_cyc_q[$], ch_q[$], wrt_cyc_q[$];

  // main-process controls
  logic        inj_done = 1'b0;
  logic [15:0] inj_rd   = 16'h0;
  logic        stub_mute = 1'b0;
  logic        gap_chk_en = 1'b0;
  int          gap_base = 0;

  assign spi.done    = stub_done | inj_done;
  assign spi.rd_data = inj_done ? inj_rd : stub_rd;

  // reference model
  logic [11:0] model_regs [4];
  int          model_idx;
  int          exp_idx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] sel_reg(input logic [1:0] i);
    case (i)
      2'd0:    return lft_ld;
      2'd1:    return rght_ld;
      2'd2:    return steer_pot;
      default: return batt;
    endcase
  endfunction

  // Monitor first, then ADC128S stub: each frame returns the conversion of
  // the channel addressed by the previous frame.
  always @(negedge clk) begin
    cyc++;
    if (spi.wrt) begin
      chk("wrt_one_cycle", 32'(prev_wrt), 32'd0);
      chk("wt_data_fmt", 32'({spi.wt_data[15:14], spi.wt_data[10:0]}), 32'd0);
      if (gap_chk_en && (((wrt_cnt - gap_base) % 2) == 1))
        chk("gap_dwell", 32'((cyc - last_done_cyc) >= GAP_CYC), 32'd1);
      ch_q.push_back(int'(spi.wt_data[13:11]));
      wrt_cyc_q.push_back(cyc);
      wrt_cnt++;
    end
    prev_wrt = spi.wrt;
    if (smpl_vld) begin
      vld_q.push_back(int'(smpl_idx));
      vld_cyc_q.push_back(cyc);
      chk("reg_same_cycle", 32'(sel_reg(smpl_idx)), 32'(adc_val[chan_tbl[smpl_idx]]));
    end
    if (rst) begin
      lat       = 0;
      stub_done = 1'b0;
    end else begin
      stub_done = 1'b0;
      if (spi.wrt) begin
        ret_ch = cur_ch;
        cur_ch = int'(spi.wt_data[13:11]);
        lat    = int'($urandom_range(8, 30));
      end else if (lat > 0) begin
        lat--;
        if ((lat == 0) && !stub_mute) begin
          stub_done     = 1'b1;
          stub_rd       = 16'($urandom);
          stub_rd[11:0] = adc_val[ret_ch];
          last_done_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  task automatic pulse_nxt();
    @(negedge clk) nxt = 1'b1;
    @(negedge clk) nxt = 1'b0;
  endtask

  task automatic model_conv();
    exp_idx_q.push_back(model_idx);
    model_regs[model_idx] = adc_val[chan_tbl[model_idx]];
    model_idx = (model_idx + 1) % 4;
  endtask

  task automatic wait_vld(input int target, input int budget);
    int n = 0;
    while ((vld_q.size() < target) && (n < budget)) begin @(negedge clk); n++; end
    chk("wait_vld", 32'(vld_q.size() >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && (n < budget)) begin @(negedge clk); n++; end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_wrt(input int budget);
    int n = 0;
    while (!spi.wrt && (n < budget)) begin @(negedge clk); n++; end
    chk("wait_wrt", 32'(spi.wrt), 32'd1);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_lft"},   32'(lft_ld),    32'(model_regs[0]));
    chk({tag, "_rght"},  32'(rght_ld),   32'(model_regs[1]));
    chk({tag, "_steer"}, 32'(steer_pot), 32'(model_regs[2]));
    chk({tag, "_batt"},  32'(batt),      32'(model_regs[3]));
  endtask

  task automatic check_vld(input string tag, input int vb);
    chk({tag, "_vld_count"}, 32'(vld_q.size() - vb), 32'(exp_idx_q.size()));
    for (int i = 0; i < exp_idx_q.size(); i++)
      if (vb + i < vld_q.size()) chk({tag, "_smpl_idx"}, 32'(vld_q[vb + i]), 32'(exp_idx_q[i]));
    exp_idx_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wrt"},      32'(spi.wrt),     32'd0);
    chk({tag, "_wt_data"},  32'(spi.wt_data), 32'd0);
    chk({tag, "_smpl_vld"}, 32'(smpl_vld),    32'd0);
    chk({tag, "_smpl_idx"}, 32'(smpl_idx),    32'd0);
    chk({tag, "_busy"},     32'(busy),        32'd0);
    chk({tag, "_ovrrun"},   32'(ovrrun),      32'd0);
    chk({tag, "_tmo_err"},  32'(tmo_err),     32'd0);
    chk({tag, "_regs"},     32'({lft_ld, rght_ld} | {8'h0, steer_pot, batt}), 32'd0);
  endtask

  initial begin
    int vb, wb, n, d0;
    rst = 1'b1;
    nxt = 1'b0;
    for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
    adc_val[CH_LFT]   = 12'h300;
    adc_val[CH_RGHT]  = 12'h2F0;
    adc_val[CH_STEER] = 12'h800;
    adc_val[CH_BATT]  = 12'hC00;
    for (int i = 0; i < 4; i++) model_regs[i] = 12'h000;
    model_idx = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");

    // Four conversions through the full rotation.
    vb = vld_q.size(); wb = ch_q.size();
    for (int k = 0; k < 4; k++) begin
      pulse_nxt();
      model_conv();
      repeat (2000) @(negedge clk);
    end
    chk("rot_wrt_count", 32'(ch_q.size() - wb), 32'd8);
    for (int k = 0; k < 8; k++)
      if (wb + k < ch_q.size()) $display("frame %0d channel %0d", k, ch_q[wb + k]);
    for (int k = 0; k < 8; k++)
      if (wb + k < ch_q.size()) chk("rot_channel", 32'(ch_q[wb + k]), 32'(chan_tbl[k / 2]));
    check_regs("rot");
    chk("rot_lft_const", 32'(lft_ld), 32'h300);
    chk("rot_batt_const", 32'(batt), 32'hC00);
    check_vld("rot", vb);

    // Fifth request wraps to the left load cell only.
    for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
    vb = vld_q.size();
    pulse_nxt();
    model_conv();
    wait_vld(vb + 1, 500);
    wait_idle(50);
    $display("wrap: lft_ld=%h", lft_ld);
    check_regs("wrap");
    check_vld("wrap", vb);

    // Two requests while busy in WAIT1: one pending, one overrun.
    vb = vld_q.size(); wb = wrt_cyc_q.size();
    pulse_nxt();
    wait_wrt(50);
    pulse_nxt();
    pulse_nxt();
    chk("ovr_set", 32'(ovrrun), 32'd1);
    model_conv();
    model_conv();
    wait_vld(vb + 2, 1000);
    wait_idle(200);
    if ((wrt_cyc_q.size() > wb + 2) && (vld_cyc_q.size() > vb))
      chk("ovr_b2b_cmd", 32'(wrt_cyc_q[wb + 2] - vld_cyc_q[vb]), 32'd2);
    else
      chk("ovr_b2b_frames", 32'd0, 32'd1);
    $display("overrun: two conversions, ovrrun=%0b", ovrrun);
    check_regs("ovr");
    check_vld("ovr", vb);
    chk("ovr_sticky", 32'(ovrrun), 32'd1);

    // Read frame never completes: timeout skips the channel.
    for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
    vb = vld_q.size();
    pulse_nxt();
    wait_wrt(50);
    @(negedge clk);
    wait_wrt(100);
    stub_mute = 1'b1;
    n = 0;
    while (!tmo_err && (n < 3000)) begin @(negedge clk); n++; end
    $display("timeout: tmo_err after %0d clks", n);
    chk("tmo_latency", 32'((n >= 2048) && (n <= 2050)), 32'd1);
    stub_mute = 1'b0;
    wait_idle(20);
    chk("tmo_err", 32'(tmo_err), 32'd1);
    chk("tmo_no_vld", 32'(vld_q.size() - vb), 32'd0);
    model_idx = (model_idx + 1) % 4;
    check_regs("tmo_keep");
    vb = vld_q.size();
    pulse_nxt();
    model_conv();
    wait_vld(vb + 1, 500);
    wait_idle(50);
    check_regs("tmo_next");
    check_vld("tmo_next", vb);

    // Reset during GAP, then a stray done.
    pulse_nxt();
    wait_wrt(50);
    d0 = done_cnt; n = 0;
    while ((done_cnt == d0) && (n < 100)) begin @(negedge clk); n++; end
    chk("gap_done_seen", 32'(done_cnt != d0), 32'd1);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = 12'h000;
    model_idx = 0;
    vb = vld_q.size(); wb = ch_q.size();
    @(negedge clk) begin inj_done = 1'b1; inj_rd = 16'($urandom); end
    @(negedge clk) inj_done = 1'b0;
    repeat (50) @(negedge clk);
    $display("reset in GAP: busy=%0b wrt_frames=%0d", busy, ch_q.size() - wb);
    chk_reset("rst_gap");
    chk("rst_gap_no_wrt", 32'(ch_q.size() - wb), 32'd0);
    chk("rst_gap_no_vld", 32'(vld_q.size() - vb), 32'd0);

    // 100 conversions with random data and spacing.
    vb = vld_q.size();
    wb = wrt_cnt;
    gap_base = wrt_cnt;
    gap_chk_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
      pulse_nxt();
      model_conv();
      wait_vld(vb + i + 1, 400);
      wait_idle(50);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    gap_chk_en = 1'b0;
    $display("soak: %0d wrt pulses over 100 conversions", wrt_cnt - wb);
    chk("soak_wrt_count", 32'(wrt_cnt - wb), 32'd200);
    check_regs("soak");
    check_vld("soak", vb);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/a2d_sched.md
Name: a2d_sched

Overview:
- Round-robin scheduler that shares the single SPI A2D link (ADC128S) among four analog channels: left load cell, right load cell, steering pot and battery.
- On each `nxt` request it runs one two-transaction conversion on the SPI monarch: a channel command frame, then a read frame.
- Each 12-bit result is latched into that channel's holding register.
- Sits between the Segway top-level timing (`nxt` comes from the inertial-valid cadence) and the SPI monarch. Consumers are the balance/steer-enable logic and the battery-low piezo warning.

Parameters:
- CH_LFT, 0, ADC channel number for left load cell
- CH_RGHT, 4, ADC channel number for right load cell
- CH_STEER, 5, ADC channel number for steering pot
- CH_BATT, 6, ADC channel number for battery
- GAP_CYC, 4, idle clocks between command and read frames (SS_n dead time)
- TMO_CYC, 2048, clocks to wait for SPI `done` before declaring a timeout

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- nxt  in  1  one-cycle request: convert the next channel in rotation
- wrt  out  1  one-cycle strobe to SPI monarch starting a 16-bit frame
- wt_data  out  16  frame to send: {2'b00, chnl[2:0], 11'h000}
- done  in  1  one-cycle pulse from SPI monarch: frame complete
- rd_data  in  16  SPI receive word; the result is rd_data[11:0]
- lft_ld  out  12  latest left load-cell sample
- rght_ld  out  12  latest right load-cell sample
- steer_pot  out  12  latest steering-pot sample
- batt  out  12  latest battery sample
- smpl_vld  out  1  one-cycle pulse, same cycle a holding register updates
- smpl_idx  out  2  rotation index (0 lft, 1 rght, 2 steer, 3 batt) qualified by smpl_vld
- busy  out  1  high whenever the FSM is not in IDLE
- ovrrun  out  1  sticky: a nxt arrived while busy with a request already pending
- tmo_err  out  1  sticky: done not received within TMO_CYC

Behaviour:
- Reset values:
  - wrt = 0, wt_data = 0, smpl_vld = 0, smpl_idx = 0, busy = 0.
  - All four holding registers = 12'h000.
  - ovrrun = 0, tmo_err = 0.
  - Rotation index = 0, pending flag = 0.
  - FSM = IDLE.
- Reset mid-frame aborts immediately. The scheduler issues no further wrt; a late `done` arriving after reset is ignored (FSM is in IDLE).
- FSM states: IDLE, CMD, WAIT1, GAP, READ, WAIT2, CAPT.
  - IDLE: on nxt or pending, go to CMD and clear pending.
  - CMD: wrt = 1 for exactly one cycle. wt_data = command for the current index. Go to WAIT1.
  - WAIT1: on done, go to GAP. rd_data is discarded (the ADC returns the previous conversion).
  - GAP: count GAP_CYC clocks, then go to READ.
  - READ: wrt = 1 for one cycle. wt_data is the same command word. Go to WAIT2.
  - WAIT2: on done, capture rd_data[11:0] and go to CAPT.
  - CAPT:
    - Write the holding register selected by the index.
    - Pulse smpl_vld with smpl_idx = index.
    - Increment index mod 4 (3 wraps to 0).
    - Return to IDLE.
- Latency: smpl_vld asserts exactly one cycle after the done that ends the read frame. Holding-register outputs change in that same cycle.
- wt_data holds its value from the CMD cycle until the next CMD cycle (the monarch may sample late).
- Request handling:
  - nxt while busy sets a one-deep pending flag.
  - nxt while busy with pending already set: set ovrrun, drop the request.
  - nxt and CAPT in the same cycle: set pending. IDLE then starts the next conversion on the following cycle.
- Timeout:
  - Counter runs in WAIT1/WAIT2 and clears on state entry.
  - At TMO_CYC with no done: set tmo_err, skip this channel without writing its register (index still advances), return to IDLE.
  - No smpl_vld is produced for the skipped channel.
- done outside WAIT1/WAIT2 is ignored.
- Sticky flags clear only on rst.
- Counter widths: $clog2(TMO_CYC+1) and $clog2(GAP_CYC+1).

Decomposition:
- Shared package (a2d_pkg):
  - enum type for FSM states.
  - Rotation-index typedef (2-bit).
  - Channel-number localparams used by the ADC model and the bench.
  - Function building the command word from a 3-bit channel number.
- One natural sub-module, a2d_sched_tmr: a loadable down-counter used for both the GAP dwell and the timeout, with a terminal-count output.
- The SPI monarch stays an existing separate instance; it is not part of this block.

Test Plan:
- Reset, then ADC model ld_cell_lft = 12'h300, ld_cell_rght = 12'h2F0, steerPot = 12'h800, batt = 12'hC00; four nxt pulses spaced 2000 clks
  -> wt_data channel fields 0, 4, 5, 6 in order; outputs = 300/2F0/800/C00; exactly 4 smpl_vld pulses with smpl_idx 0, 1, 2, 3.
- Fifth nxt after the four above
  -> index wraps; only lft_ld updates, with smpl_idx = 0.
- nxt asserted twice while busy in WAIT1
  -> first sets pending, second sets ovrrun = 1; exactly two conversions complete back to back, and the second CMD follows CAPT by one IDLE cycle.
- SPI stub withholds done in WAIT2
  -> after 2048 clks tmo_err = 1, no smpl_vld, register keeps its old value, index advances; the next nxt converts the following channel normally.
- rst asserted during GAP, then a stray done injected
  -> all outputs return to reset values, no wrt is issued, and the stray done has no effect.
- Count wrt pulses across 100 conversions
  -> exactly 200 wrt pulses, each one cycle wide, with ≥ GAP_CYC clks between the done of the command frame and the wrt of the read frame.
